// File: rtl/sram_ctrl.sv
// Bridges a 32-bit single-outstanding request port to a 16-bit asynchronous SRAM,
// splitting each access into registered LO/HI halfword phases with optional wait states.
module sram_ctrl #(
    parameter int SRAM_AW     = 18,
    parameter int WAIT_CYCLES = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_read,
    input  logic               req_write,
    input  logic [SRAM_AW:0]   req_addr,
    input  logic [31:0]        req_wdata,
    input  logic [3:0]         req_be,
    output logic               req_ready,
    output logic               rsp_valid,
    output logic [31:0]        rsp_rdata,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic [1:0]         sram_be_n,
    output logic [SRAM_AW-1:0] sram_addr,
    inout  wire  [15:0]        sram_dq
);

    typedef enum logic [2:0] {IDLE, SET_LO, STB_LO, SET_HI, STB_HI} state_t;

    localparam logic [2:0] LAST_STB = 3'(WAIT_CYCLES);

    state_t             state, state_nxt;
    logic [2:0]         cnt, cnt_nxt;
    logic               op_write, op_write_nxt;
    logic [SRAM_AW-2:0] op_word, op_word_nxt;
    logic [31:0]        op_wdata, op_wdata_nxt;
    logic [3:0]         op_be, op_be_nxt;
    logic [15:0]        lo_data, lo_data_nxt;
    logic [31:0]        rdata_nxt;
    logic               rsp_valid_nxt;
    logic               ce_n_nxt, oe_n_nxt, we_n_nxt;
    logic [1:0]         be_n_nxt;
    logic [SRAM_AW-1:0] addr_nxt;
    logic               dq_oe, dq_oe_nxt;
    logic [15:0]        dq_out, dq_out_nxt;
    logic               accept, stb_done, hi_phase;
    logic               unused_addr_bits;

    assign req_ready        = (state == IDLE);
    assign accept           = req_ready && (req_read || req_write);
    assign stb_done         = (cnt == LAST_STB);
    assign sram_dq          = dq_oe ? dq_out : 16'bz;
    assign unused_addr_bits = ^req_addr[1:0];

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        op_write_nxt  = op_write;
        op_word_nxt   = op_word;
        op_wdata_nxt  = op_wdata;
        op_be_nxt     = op_be;
        lo_data_nxt   = lo_data;
        rdata_nxt     = rsp_rdata;
        rsp_valid_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    // Write wins over a simultaneous read; reads always run both halves.
                    op_write_nxt = req_write;
                    op_word_nxt  = req_addr[SRAM_AW:2];
                    op_wdata_nxt = req_wdata;
                    op_be_nxt    = req_write ? req_be : 4'b1111;
                    if (!req_write || req_be[1:0] != 2'b00)
                        state_nxt = SET_LO;
                    else if (req_be[3:2] != 2'b00)
                        state_nxt = SET_HI;
                end
            end
            SET_LO: begin
                state_nxt = STB_LO;
                cnt_nxt   = 3'd0;
            end
            STB_LO: begin
                if (stb_done) begin
                    lo_data_nxt = sram_dq;
                    state_nxt   = (op_be[3:2] != 2'b00) ? SET_HI : IDLE;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
            SET_HI: begin
                state_nxt = STB_HI;
                cnt_nxt   = 3'd0;
            end
            STB_HI: begin
                if (stb_done) begin
                    state_nxt = IDLE;
                    if (!op_write) begin
                        rdata_nxt     = {sram_dq, lo_data};
                        rsp_valid_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Pin values are derived from the state being entered so they can be registered.
        hi_phase   = (state_nxt == SET_HI) || (state_nxt == STB_HI);
        ce_n_nxt   = 1'b1;
        oe_n_nxt   = 1'b1;
        we_n_nxt   = 1'b1;
        be_n_nxt   = 2'b11;
        addr_nxt   = sram_addr;
        dq_oe_nxt  = 1'b0;
        dq_out_nxt = dq_out;
        if (state_nxt != IDLE) begin
            ce_n_nxt = 1'b0;
            addr_nxt = {op_word_nxt, hi_phase};
            if (op_write_nxt) begin
                be_n_nxt   = hi_phase ? ~op_be_nxt[3:2] : ~op_be_nxt[1:0];
                we_n_nxt   = (state_nxt == SET_LO) || (state_nxt == SET_HI);
                dq_oe_nxt  = 1'b1;
                dq_out_nxt = hi_phase ? op_wdata_nxt[31:16] : op_wdata_nxt[15:0];
            end else begin
                oe_n_nxt = 1'b0;
                be_n_nxt = 2'b00;
            end
        end
    end

    // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            op_write  <= 1'b0;
            op_word   <= '0;
            op_wdata  <= '0;
            op_be     <= '0;
            lo_data   <= '0;
            rsp_rdata <= '0;
            rsp_valid <= 1'b0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_be_n <= 2'b11;
            sram_addr <= '0;
            dq_oe     <= 1'b0;
            dq_out    <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            op_write  <= op_write_nxt;
            op_word   <= op_word_nxt;
            op_wdata  <= op_wdata_nxt;
            op_be     <= op_be_nxt;
            lo_data   <= lo_data_nxt;
            rsp_rdata <= rdata_nxt;
            rsp_valid <= rsp_valid_nxt;
            sram_ce_n <= ce_n_nxt;
            sram_oe_n <= oe_n_nxt;
            sram_we_n <= we_n_nxt;
            sram_be_n <= be_n_nxt;
            sram_addr <= addr_nxt;
            dq_oe     <= dq_oe_nxt;
            dq_out    <= dq_out_nxt;
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: two instances (W=0 and W=3) on behavioural SRAMs,
// checked cycle by cycle against a word-level memory model and phase-timing rules.
module tb_sram_ctrl;

    localparam int AW = 18;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          rd [2];
    logic          wr [2];
    logic [AW:0]   addr [2];
    logic [31:0]   wdata [2];
    logic [3:0]    be [2];
    logic          ready [2];
    logic          rsp_valid [2];
    logic [31:0]   rdata [2];
    logic          ce_n [2];
    logic          oe_n [2];
    logic          we_n [2];
    logic [1:0]    be_n [2];
    logic [AW-1:0] saddr [2];
    wire  [15:0]   dq0, dq1;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] last_rd [2];
    logic [31:0] model0 [int];
    logic [31:0] model1 [int];
    logic [15:0] sram0 [0:(1<<AW)-1];
    logic [15:0] sram1 [0:(1<<AW)-1];

    sram_ctrl #(.SRAM_AW(AW), .WAIT_CYCLES(0)) dut (
        .clk(clk), .rst(rst),
        .req_read(rd[0]), .req_write(wr[0]), .req_addr(addr[0]),
        .req_wdata(wdata[0]), .req_be(be[0]),
        .req_ready(ready[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rdata[0]),
        .sram_ce_n(ce_n[0]), .sram_oe_n(oe_n[0]), .sram_we_n(we_n[0]),
        .sram_be_n(be_n[0]), .sram_addr(saddr[0]), .sram_dq(dq0)
    );

    sram_ctrl #(.SRAM_AW(AW), .WAIT_CYCLES(3)) dut_w3 (
        .clk(clk), .rst(rst),
        .req_read(rd[1]), .req_write(wr[1]), .req_addr(addr[1]),
        .req_wdata(wdata[1]), .req_be(be[1]),
        .req_ready(ready[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rdata[1]),
        .sram_ce_n(ce_n[1]), .sram_oe_n(oe_n[1]), .sram_we_n(we_n[1]),
        .sram_be_n(be_n[1]), .sram_addr(saddr[1]), .sram_dq(dq1)
    );

    // Asynchronous SRAM models: drive on read, latch byte lanes while WE_N is low.
    assign dq0 = (!ce_n[0] && !oe_n[0] && we_n[0]) ? sram0[saddr[0]] : 16'hzzzz;
    assign dq1 = (!ce_n[1] && !oe_n[1] && we_n[1]) ? sram1[saddr[1]] : 16'hzzzz;

    always @(negedge clk) begin
        if (!ce_n[0] && !we_n[0]) begin
            if (!be_n[0][0]) sram0[saddr[0]][7:0]  <= dq0[7:0];
            if (!be_n[0][1]) sram0[saddr[0]][15:8] <= dq0[15:8];
        end
        if (!ce_n[1] && !we_n[1]) begin
            if (!be_n[1][0]) sram1[saddr[1]][7:0]  <= dq1[7:0];
            if (!be_n[1][1]) sram1[saddr[1]][15:8] <= dq1[15:8];
        end
    end

    function automatic logic [31:0] mread(input int s, input int k);
        if (s == 0) return model0.exists(k) ? model0[k] : 32'h0;
        return model1.exists(k) ? model1[k] : 32'h0;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] b);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++)
            if (b[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Issues one request and checks every pin cycle against the phase-timing rules.
    task automatic do_req(input int s, input bit r, input bit w, input logic [AW:0] a,
                          input logic [31:0] d, input logic [3:0] b, input int wc);
        logic [AW-2:0] wd;
        logic [3:0]    eb;
        bit            ph [2];
        int            nph, plen, total;
        logic [31:0]   exp_rd, exp_hold;
        logic [AW+6:0] got_v, exp_v;
        logic [6:0]    got_i, exp_i;
        logic [15:0]   got_dq;
        wd     = a[AW:2];
        eb     = w ? b : 4'hF;
        nph    = 0;
        if (eb[1:0] != 2'b00) begin ph[nph] = 1'b0; nph++; end
        if (eb[3:2] != 2'b00) begin ph[nph] = 1'b1; nph++; end
        plen   = 2 + wc;
        total  = nph * plen;
        exp_rd = mread(s, int'(wd));

        vectors++;
        if (ready[s] !== 1'b1) begin
            miscompares++;
            $display("FAIL accept_ready s=%0d got=%b exp=1", s, ready[s]);
        end
        rd[s] = r; wr[s] = w; addr[s] = a; wdata[s] = d; be[s] = b;
        @(posedge clk);
        #1;
        rd[s] = 1'b0; wr[s] = 1'b0;
        addr[s] = (AW+1)'($urandom); wdata[s] = $urandom; be[s] = 4'($urandom);
        if (w) begin
            if (s == 0) model0[int'(wd)] = merge(mread(0, int'(wd)), d, b);
            else        model1[int'(wd)] = merge(mread(1, int'(wd)), d, b);
        end

        for (int k = 1; k <= total + 1; k++) begin
            @(negedge clk);
            if (k <= total) begin
                int p, off;
                bit hi;
                p   = (k - 1) / plen;
                off = (k - 1) % plen;
                hi  = ph[p];
                got_v = {ready[s], rsp_valid[s], ce_n[s], oe_n[s], we_n[s], be_n[s], saddr[s]};
                exp_v = {1'b0, 1'b0, 1'b0, w, !(w && off != 0),
                         w ? ~(hi ? b[3:2] : b[1:0]) : 2'b00, wd, hi};
                vectors++;
                if (got_v !== exp_v) begin
                    miscompares++;
                    $display("FAIL pins s=%0d cycle=%0d got=%h exp=%h", s, k, got_v, exp_v);
                end
                if (w) begin
                    got_dq = (s == 0) ? dq0 : dq1;
                    vectors++;
                    if (got_dq !== (hi ? d[31:16] : d[15:0])) begin
                        miscompares++;
                        $display("FAIL dq s=%0d cycle=%0d got=%h exp=%h", s, k, got_dq,
                                 hi ? d[31:16] : d[15:0]);
                    end
                end
            end else begin
                got_i = {ready[s], rsp_valid[s], ce_n[s], oe_n[s], we_n[s], be_n[s]};
                exp_i = {1'b1, r && !w, 1'b1, 1'b1, 1'b1, 2'b11};
                vectors++;
                if (got_i !== exp_i) begin
                    miscompares++;
                    $display("FAIL idle s=%0d cycle=%0d got=%b exp=%b", s, k, got_i, exp_i);
                end
                exp_hold = (r && !w) ? exp_rd : last_rd[s];
                last_rd[s] = exp_hold;
                vectors++;
                if (rdata[s] !== exp_hold) begin
                    miscompares++;
                    $display("FAIL rdata s=%0d got=%h exp=%h", s, rdata[s], exp_hold);
                end
            end
        end
    endtask

    task automatic test_reset;
        logic [AW+6:0] exp_v;
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            rd[s] = 0; wr[s] = 0; addr[s] = '0; wdata[s] = '0; be[s] = '0;
            last_rd[s] = '0;
        end
        @(negedge clk);
        exp_v = {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b11, {AW{1'b0}}};
        for (int s = 0; s < 2; s++) begin
            vectors++;
            if ({ready[s], rsp_valid[s], ce_n[s], oe_n[s], we_n[s], be_n[s], saddr[s]} !== exp_v
                || rdata[s] !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_values s=%0d got=%h/%h exp=%h/0", s,
                         {ready[s], rsp_valid[s], ce_n[s], oe_n[s], we_n[s], be_n[s], saddr[s]},
                         rdata[s], exp_v);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_readback;
        do_req(0, 0, 1, 19'h00010, 32'hDEADBEEF, 4'hF, 0);
        do_req(0, 1, 0, 19'h00010, 32'h0, 4'h0, 0);
        vectors++;
        if (rdata[0] !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL readback got=%h exp=deadbeef", rdata[0]);
        end
    endtask

    task automatic test_byte_merge;
        do_req(0, 0, 1, 19'h00020, 32'h11223344, 4'hF, 0);
        do_req(0, 0, 1, 19'h00020, 32'hAABBCCDD, 4'b0100, 0);
        do_req(0, 1, 0, 19'h00020, 32'h0, 4'h0, 0);
        vectors++;
        if (rdata[0] !== 32'h11BB3344) begin
            miscompares++;
            $display("FAIL byte_merge got=%h exp=11bb3344", rdata[0]);
        end
    endtask

    task automatic test_be_zero;
        do_req(0, 0, 1, 19'h00030, 32'h01020304, 4'hF, 0);
        do_req(0, 0, 1, 19'h00030, 32'hFFFFFFFF, 4'h0, 0);
        do_req(0, 1, 0, 19'h00030, 32'h0, 4'h0, 0);
        vectors++;
        if (rdata[0] !== 32'h01020304) begin
            miscompares++;
            $display("FAIL be_zero got=%h exp=01020304", rdata[0]);
        end
    endtask

    task automatic test_read_write_collision;
        do_req(0, 1, 1, 19'h00040, 32'h5A5A5A5A, 4'hF, 0);
        do_req(0, 1, 0, 19'h00040, 32'h0, 4'h0, 0);
        vectors++;
        if (rdata[0] !== 32'h5A5A5A5A) begin
            miscompares++;
            $display("FAIL collision got=%h exp=5a5a5a5a", rdata[0]);
        end
    endtask

    task automatic test_wait_states;
        do_req(1, 0, 1, 19'h00100, 32'hCAFEF00D, 4'hF, 3);
        do_req(1, 1, 0, 19'h00100, 32'h0, 4'h0, 3);
        do_req(1, 0, 1, 19'h00100, 32'h12345678, 4'b0011, 3);
        do_req(1, 1, 0, 19'h00100, 32'h0, 4'h0, 3);
        vectors++;
        if (rdata[1] !== 32'hCAFE5678) begin
            miscompares++;
            $display("FAIL wait_states got=%h exp=cafe5678", rdata[1]);
        end
    endtask

    task automatic test_back_to_back;
        do_req(0, 0, 1, 19'h00050, 32'h0BADCAFE, 4'hF, 0);
        do_req(0, 1, 0, 19'h00050, 32'h0, 4'h0, 0);
        do_req(0, 1, 0, 19'h00010, 32'h0, 4'h0, 0);
        do_req(0, 0, 1, 19'h00050, 32'h77665544, 4'b1000, 0);
        do_req(0, 1, 0, 19'h00050, 32'h0, 4'h0, 0);
        vectors++;
        if (rdata[0] !== 32'h77ADCAFE) begin
            miscompares++;
            $display("FAIL back_to_back got=%h exp=77adcafe", rdata[0]);
        end
    endtask

    task automatic test_reset_midaccess;
        logic [AW+6:0] exp_v;
        rd[0] = 1'b1; addr[0] = 19'h00010;
        @(posedge clk);
        #1;
        rd[0] = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2;
        vectors++;
        if (ce_n[0] !== 1'b0 || oe_n[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL pre_reset_busy got=%b%b exp=00", ce_n[0], oe_n[0]);
        end
        rst = 1'b1;
        #1;
        exp_v = {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b11, {AW{1'b0}}};
        vectors++;
        if ({ready[0], rsp_valid[0], ce_n[0], oe_n[0], we_n[0], be_n[0], saddr[0]} !== exp_v
            || rdata[0] !== 32'h0) begin
            miscompares++;
            $display("FAIL async_reset got=%h/%h exp=%h/0",
                     {ready[0], rsp_valid[0], ce_n[0], oe_n[0], we_n[0], be_n[0], saddr[0]},
                     rdata[0], exp_v);
        end
        last_rd[0] = '0;
        last_rd[1] = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            vectors++;
            if (rsp_valid[0] !== 1'b0 || ready[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL post_reset_quiet cycle=%0d got=%b%b exp=01", k, rsp_valid[0], ready[0]);
            end
        end
        do_req(0, 1, 0, 19'h00010, 32'h0, 4'h0, 0);
    endtask

    task automatic test_random;
        logic [AW-2:0] words [16];
        logic [AW-2:0] wd;
        int kind;
        for (int i = 0; i < 16; i++) words[i] = (AW-1)'(17'h00200 + i);
        words[15] = '1;
        for (int i = 0; i < 16; i++)
            do_req(0, 0, 1, {words[i], 2'b00}, $urandom, 4'hF, 0);
        for (int n = 0; n < 80; n++) begin
            wd   = words[$urandom_range(0, 15)];
            kind = $urandom_range(0, 3);
            do_req(0, kind == 0 || kind == 3, kind != 0, {wd, 2'($urandom)},
                   $urandom, 4'($urandom), 0);
        end
    endtask

    initial begin
        test_reset();
        test_write_readback();
        test_byte_merge();
        test_be_zero();
        test_read_write_collision();
        test_wait_states();
        test_back_to_back();
        test_reset_midaccess();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
